// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default sample/slot widths and the run/idle state type.
package i2s_pkg;

    localparam int unsigned I2S_DATA_W = 24;
    localparam int unsigned I2S_SLOT_W = 32;

    typedef enum logic {
        IDLE,
        RUN
    } i2s_state_e;

endpackage

// File: rtl/i2s_bclk_gen.sv
// I2S bit-clock divider: registered bclk plus single-cycle rise/fall strobes.
module i2s_bclk_gen #(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic bclk,
    output logic rise,
    output logic fall
);

    localparam int unsigned DivW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic            bclk_q, bclk_d;
    logic            tick;

    always_comb begin
        tick      = run && (div_cnt_q == DivW'(BCLK_DIV - 1));
        div_cnt_d = '0;
        bclk_d    = 1'b0;
        if (run) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
            bclk_d    = bclk_q ^ tick;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

    assign bclk = bclk_q;
    assign rise = tick && !bclk_q;
    assign fall = tick && bclk_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S stereo transmitter: one-entry sample buffer, frame FSM and MSB-first shifters.
// Optional build macro I2S_TX_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W   = I2S_DATA_W,
    parameter int unsigned SLOT_W   = I2S_SLOT_W,
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              i2s_bclk,
    output logic              i2s_ws,
    output logic              i2s_sd,
    output logic              underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_cnt
`endif
);

    localparam int unsigned FramePos = 2 * SLOT_W;
    localparam int unsigned PosW     = $clog2(FramePos);

    i2s_state_e        state_q, state_d;
    logic [PosW-1:0]   pos_q, pos_d, pos_next;
    logic              ws_q, ws_d, sd_q, sd_d, underrun_q, underrun_d;
    logic              buf_full_q, buf_full_d;
    logic [DATA_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
    logic [DATA_W-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
    logic              run, frame_end, load, accept;
    logic              bclk_rise, bclk_fall, unused_rise;

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .bclk  (i2s_bclk),
        .rise  (bclk_rise),
        .fall  (bclk_fall)
    );

    assign unused_rise = bclk_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (frame_end && !en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The IDLE->RUN edge doubles as the frame load, so the first RUN clk already holds p = 0.
    always_comb begin
        run        = (state_q == RUN);
        frame_end  = run && bclk_fall && (pos_q == PosW'(FramePos - 1));
        load       = en && (!run || frame_end);
        s_ready    = !buf_full_q || load;
        accept     = s_valid && s_ready;
        underrun_d = load && !buf_full_q;
    end

    // Load consumes the old entry before a same-cycle accept refills it.
    always_comb begin
        buf_full_d = buf_full_q;
        buf_l_d    = buf_l_q;
        buf_r_d    = buf_r_q;
        if (load) buf_full_d = 1'b0;
        if (accept) begin
            buf_full_d = 1'b1;
            buf_l_d    = s_left;
            buf_r_d    = s_right;
        end
    end

    always_comb begin
        pos_next = (pos_q == PosW'(FramePos - 1)) ? '0 : pos_q + 1'b1;
        pos_d    = pos_q;
        ws_d     = ws_q;
        sd_d     = sd_q;
        sh_l_d   = sh_l_q;
        sh_r_d   = sh_r_q;
        if (load) begin
            sh_l_d = buf_full_q ? buf_l_q : '0;
            sh_r_d = buf_full_q ? buf_r_q : '0;
        end
        if (run && bclk_fall) begin
            pos_d = pos_next;
            ws_d  = (pos_next >= PosW'(SLOT_W));
            sd_d  = 1'b0;
            if ((pos_next != '0) && (pos_next <= PosW'(DATA_W))) begin
                sd_d   = sh_l_q[DATA_W-1];
                sh_l_d = sh_l_q << 1;
            end else if ((pos_next > PosW'(SLOT_W)) &&
                         (pos_next <= PosW'(SLOT_W + DATA_W))) begin
                sd_d   = sh_r_q[DATA_W-1];
                sh_r_d = sh_r_q << 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q      <= '0;
            ws_q       <= 1'b0;
            sd_q       <= 1'b0;
            underrun_q <= 1'b0;
            buf_full_q <= 1'b0;
            buf_l_q    <= '0;
            buf_r_q    <= '0;
            sh_l_q     <= '0;
            sh_r_q     <= '0;
        end else begin
            pos_q      <= pos_d;
            ws_q       <= ws_d;
            sd_q       <= sd_d;
            underrun_q <= underrun_d;
            buf_full_q <= buf_full_d;
            buf_l_q    <= buf_l_d;
            buf_r_q    <= buf_r_d;
            sh_l_q     <= sh_l_d;
            sh_r_q     <= sh_r_d;
        end
    end

    assign i2s_ws   = ws_q;
    assign i2s_sd   = sd_q;
    assign underrun = underrun_q;

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ucnt_q <= '0;
        end else if (underrun_d && (ucnt_q != 16'hFFFF)) begin
            ucnt_q <= ucnt_q + 16'd1;
        end
    end

    assign underrun_cnt = ucnt_q;
`endif

endmodule
